// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and default constants for the parking occupancy block
package parking_pkg;

   // Entry barrier handshake states
   typedef enum logic [2:0] {
      G_IDLE  = 3'd0,
      G_RAISE = 3'd1,
      G_UP    = 3'd2,
      G_LOWER = 3'd3,
      G_FAULT = 3'd4
   } gate_state_t;

   localparam int DEF_CAPACITY     = 16;
   localparam int DEF_CNT_W        = 5;
   localparam int DEF_GATE_TIMEOUT = 200;
   localparam int DEF_TO_W         = 8;

endpackage

// File: rtl/parking_edge_det.sv
// rtl/parking_edge_det.sv - single-bit rising-edge detector
module parking_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic evt
);

   logic din_d;

   // Remember the previous level so a held-high input yields one event
   always_ff @(posedge clk) begin
      if (!rst_n) din_d <= 1'b0;
      else        din_d <= din;
   end

   assign evt = din & ~din_d;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - occupancy counter, sticky error flags and entry gate handshake
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY     = DEF_CAPACITY,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
   parameter int TO_W         = DEF_TO_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             entering,
   input  logic             exiting,
   input  logic             veh_req,
   input  logic             gate_ack,
   input  logic             err_clr,
   output logic             gate_open,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             err_overflow,
   output logic             err_underflow,
   output logic             gate_fault
);

   localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(GATE_TIMEOUT - 1);

   logic             ent_evt, ext_evt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt, udf_nxt;
   gate_state_t      state, state_nxt;
   logic [TO_W-1:0]  timer, timer_nxt;
   logic             gate_open_nxt, gate_fault_nxt;

   parking_edge_det u_ent_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (entering),
      .evt   (ent_evt)
   );

   parking_edge_det u_ext_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (exiting),
      .evt   (ext_evt)
   );

   // Next occupancy and error flags; simultaneous entry and exit cancel out
   always_comb begin
      cnt_nxt = count;
      ovf_nxt = err_clr ? 1'b0 : err_overflow;
      udf_nxt = err_clr ? 1'b0 : err_underflow;
      if (ent_evt && !ext_evt) begin
         if (count < CAP) cnt_nxt = count + 1'b1;
         else             ovf_nxt = 1'b1;
      end else if (ext_evt && !ent_evt) begin
         if (count != '0) cnt_nxt = count - 1'b1;
         else             udf_nxt = 1'b1;
      end
   end

   // Occupancy register with flags derived from the new count on the same edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count         <= '0;
         full          <= 1'b0;
         empty         <= 1'b1;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         count         <= cnt_nxt;
         full          <= (cnt_nxt == CAP);
         empty         <= (cnt_nxt == '0);
         err_overflow  <= ovf_nxt;
         err_underflow <= udf_nxt;
      end
   end

   // Gate next state, travel timer and registered output values
   always_comb begin
      state_nxt = state;
      case (state)
         G_IDLE:  if (veh_req && !full) state_nxt = G_RAISE;
         G_RAISE: begin
            if (gate_ack)              state_nxt = G_UP;
            else if (timer == TO_LAST) state_nxt = G_FAULT;
         end
         G_UP:    if (ent_evt || !veh_req) state_nxt = G_LOWER;
         G_LOWER: begin
            if (!gate_ack)             state_nxt = G_IDLE;
            else if (timer == TO_LAST) state_nxt = G_FAULT;
         end
         G_FAULT: if (err_clr) state_nxt = G_IDLE;
         default: state_nxt = G_IDLE;
      endcase

      timer_nxt = '0;
      if ((state_nxt == state) && ((state == G_RAISE) || (state == G_LOWER)))
         timer_nxt = timer + 1'b1;

      gate_open_nxt = (state_nxt == G_RAISE) || (state_nxt == G_UP);

      // A new fault outranks a clear arriving on the same cycle
      if (state_nxt == G_FAULT) gate_fault_nxt = 1'b1;
      else if (err_clr)         gate_fault_nxt = 1'b0;
      else                      gate_fault_nxt = gate_fault;
   end

   // Gate state register; outputs are registered so they carry no input paths
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= G_IDLE;
         timer      <= '0;
         gate_open  <= 1'b0;
         gate_fault <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         gate_open  <= gate_open_nxt;
         gate_fault <= gate_fault_nxt;
      end
   end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb/tb_parking_occupancy_ctrl.sv - self-checking bench for parking_occupancy_ctrl
module tb_parking_occupancy_ctrl;

   localparam int CAP = 16;
   localparam int TMO = 200;

   logic       clk, rst_n, entering, exiting, veh_req, gate_ack, err_clr;
   logic       gate_open, full, empty, err_overflow, err_underflow, gate_fault;
   logic [4:0] count;

   int total = 0;
   int bad   = 0;

   // Reference: occupancy as a plain integer, flags as bits, previous input levels
   int m_cnt;
   bit m_ovf, m_udf, m_ent_prev, m_ext_prev;

   parking_occupancy_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .entering      (entering),
      .exiting       (exiting),
      .veh_req       (veh_req),
      .gate_ack      (gate_ack),
      .err_clr       (err_clr),
      .gate_open     (gate_open),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .gate_fault    (gate_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance the model with the current inputs, then pass one rising edge
   task automatic tick();
      bit ent, ext;
      if (!rst_n) begin
         m_cnt = 0; m_ovf = 0; m_udf = 0; m_ent_prev = 0; m_ext_prev = 0;
      end else begin
         ent = entering && !m_ent_prev;
         ext = exiting && !m_ext_prev;
         if (err_clr) begin m_ovf = 0; m_udf = 0; end
         if (ent && !ext) begin
            if (m_cnt < CAP) m_cnt++; else m_ovf = 1;
         end else if (ext && !ent) begin
            if (m_cnt > 0) m_cnt--; else m_udf = 1;
         end
         m_ent_prev = entering;
         m_ext_prev = exiting;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; entering = 0; exiting = 0; veh_req = 0; gate_ack = 0; err_clr = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; entering = 1'($urandom); exiting = 1'($urandom);
      veh_req = 1; gate_ack = 0; err_clr = 0;
      tick();
      tick();
      total += 7;
      if (count !== 5'd0)        begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      if (full !== 1'b0)         begin bad++; $display("FAIL reset_full: got %b want 0", full); end
      if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", err_overflow); end
      if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_udf: got %b want 0", err_underflow); end
      if (gate_fault !== 1'b0)   begin bad++; $display("FAIL reset_fault: got %b want 0", gate_fault); end
      if (gate_open !== 1'b0)    begin bad++; $display("FAIL reset_gate: got %b want 0", gate_open); end
      entering = 0; exiting = 0; veh_req = 0;
      rst_n = 1;
      tick();
   endtask

   task automatic test_entries();
      do_reset();
      for (int p = 0; p < 3; p++) begin
         entering = 1;
         tick();
         total++;
         if (count !== 5'(p + 1)) begin bad++; $display("FAIL entry_latency: got %0d want %0d", count, p + 1); end
         for (int h = 0; h < 3; h++) tick();
         total++;
         if (count !== 5'(p + 1)) begin bad++; $display("FAIL entry_hold: got %0d want %0d", count, p + 1); end
         entering = 0;
         tick();
      end
      total += 3;
      if (empty !== 1'b0)         begin bad++; $display("FAIL entry_empty: got %b want 0", empty); end
      if (err_overflow !== 1'b0)  begin bad++; $display("FAIL entry_ovf: got %b want 0", err_overflow); end
      if (err_underflow !== 1'b0) begin bad++; $display("FAIL entry_udf: got %b want 0", err_underflow); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int p = 0; p < CAP + 1; p++) begin
         entering = 1; tick();
         entering = 0; tick();
      end
      total += 3;
      if (count !== 5'(CAP))     begin bad++; $display("FAIL ovf_count: got %0d want %0d", count, CAP); end
      if (full !== 1'b1)         begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
      if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
      err_clr = 1; tick(); err_clr = 0;
      total += 2;
      if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", err_overflow); end
      if (count !== 5'(CAP))     begin bad++; $display("FAIL ovf_clear_count: got %0d want %0d", count, CAP); end
   endtask

   task automatic test_underflow();
      do_reset();
      exiting = 1; tick(); exiting = 0; tick();
      total += 3;
      if (count !== 5'd0)         begin bad++; $display("FAIL udf_count: got %0d want 0", count); end
      if (err_underflow !== 1'b1) begin bad++; $display("FAIL udf_flag: got %b want 1", err_underflow); end
      if (empty !== 1'b1)         begin bad++; $display("FAIL udf_empty: got %b want 1", empty); end
      err_clr = 1; tick(); err_clr = 0;
      for (int p = 0; p < 5; p++) begin
         entering = 1; tick();
         entering = 0; tick();
      end
      entering = 1; exiting = 1; tick();
      total += 3;
      if (count !== 5'd5)         begin bad++; $display("FAIL both_count: got %0d want 5", count); end
      if (err_overflow !== 1'b0)  begin bad++; $display("FAIL both_ovf: got %b want 0", err_overflow); end
      if (err_underflow !== 1'b0) begin bad++; $display("FAIL both_udf: got %b want 0", err_underflow); end
      entering = 0; exiting = 0; tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i < 300) begin
            entering = ($urandom_range(0, 3) != 0);
            exiting  = ($urandom_range(0, 5) == 0);
         end else begin
            entering = ($urandom_range(0, 5) == 0);
            exiting  = ($urandom_range(0, 3) != 0);
         end
         err_clr = ($urandom_range(0, 24) == 0);
         tick();
         total += 6;
         if (count !== 5'(m_cnt)) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, count, m_cnt); end
         if (full !== (m_cnt == CAP)) begin bad++; $display("FAIL rnd_full: cyc %0d got %b want %b", i, full, m_cnt == CAP); end
         if (empty !== (m_cnt == 0)) begin bad++; $display("FAIL rnd_empty: cyc %0d got %b want %b", i, empty, m_cnt == 0); end
         if (err_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf: cyc %0d got %b want %b", i, err_overflow, m_ovf); end
         if (err_underflow !== m_udf) begin bad++; $display("FAIL rnd_udf: cyc %0d got %b want %b", i, err_underflow, m_udf); end
         if (gate_open !== 1'b0) begin bad++; $display("FAIL rnd_gate: cyc %0d got %b want 0", i, gate_open); end
      end
      entering = 0; exiting = 0; err_clr = 0;
      tick();
   endtask

   task automatic test_gate_handshake();
      do_reset();
      veh_req = 1; gate_ack = 0;
      tick();
      total++;
      if (gate_open !== 1'b1) begin bad++; $display("FAIL hs_raise: got %b want 1", gate_open); end
      for (int i = 0; i < 9; i++) tick();
      gate_ack = 1; tick();
      tick();
      total += 2;
      if (gate_open !== 1'b1)  begin bad++; $display("FAIL hs_up: got %b want 1", gate_open); end
      if (gate_fault !== 1'b0) begin bad++; $display("FAIL hs_up_fault: got %b want 0", gate_fault); end
      entering = 1; tick();
      total += 2;
      if (gate_open !== 1'b0)  begin bad++; $display("FAIL hs_lower: got %b want 0", gate_open); end
      if (count !== 5'(m_cnt)) begin bad++; $display("FAIL hs_count: got %0d want %0d", count, m_cnt); end
      entering = 0; veh_req = 0;
      for (int i = 0; i < 11; i++) tick();
      gate_ack = 0; tick();
      veh_req = 1; tick();
      total += 2;
      if (gate_open !== 1'b1) begin bad++; $display("FAIL hs_idle_again: got %b want 1", gate_open); end
      if (count !== 5'd1)     begin bad++; $display("FAIL hs_final_count: got %0d want 1", count); end
      gate_ack = 1; tick();
      veh_req = 0; tick();
      total += 2;
      if (gate_open !== 1'b0) begin bad++; $display("FAIL balk_lower: got %b want 0", gate_open); end
      if (count !== 5'd1)     begin bad++; $display("FAIL balk_count: got %0d want 1", count); end
      gate_ack = 0; tick();
   endtask

   task automatic test_gate_timeout();
      do_reset();
      veh_req = 1; gate_ack = 0;
      tick();
      for (int i = 0; i < TMO - 1; i++) tick();
      total += 2;
      if (gate_fault !== 1'b0) begin bad++; $display("FAIL tmo_raise_early: got %b want 0", gate_fault); end
      if (gate_open !== 1'b1)  begin bad++; $display("FAIL tmo_raise_open: got %b want 1", gate_open); end
      tick();
      total += 2;
      if (gate_fault !== 1'b1) begin bad++; $display("FAIL tmo_raise_fault: got %b want 1", gate_fault); end
      if (gate_open !== 1'b0)  begin bad++; $display("FAIL tmo_raise_drop: got %b want 0", gate_open); end
      err_clr = 1; tick(); err_clr = 0;
      total++;
      if (gate_fault !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", gate_fault); end
      tick();
      total++;
      if (gate_open !== 1'b1) begin bad++; $display("FAIL tmo_reraise: got %b want 1", gate_open); end
      gate_ack = 1; tick();
      veh_req = 0; tick();
      for (int i = 0; i < TMO - 1; i++) tick();
      total++;
      if (gate_fault !== 1'b0) begin bad++; $display("FAIL tmo_lower_early: got %b want 0", gate_fault); end
      tick();
      total++;
      if (gate_fault !== 1'b1) begin bad++; $display("FAIL tmo_lower_fault: got %b want 1", gate_fault); end
      gate_ack = 0; err_clr = 1; tick(); err_clr = 0;
   endtask

   task automatic test_full_blocks();
      do_reset();
      for (int p = 0; p < CAP; p++) begin
         entering = 1; tick();
         entering = 0; tick();
      end
      veh_req = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (gate_open !== 1'b0) begin bad++; $display("FAIL full_block: got %b want 0", gate_open); end
      end
      veh_req = 0; tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int p = 0; p < 2; p++) begin
         entering = 1; tick();
         entering = 0; tick();
      end
      veh_req = 1; tick();
      total++;
      if (gate_open !== 1'b1) begin bad++; $display("FAIL mid_raise: got %b want 1", gate_open); end
      rst_n = 0; tick();
      total += 3;
      if (gate_open !== 1'b0) begin bad++; $display("FAIL mid_gate: got %b want 0", gate_open); end
      if (count !== 5'd0)     begin bad++; $display("FAIL mid_count: got %0d want 0", count); end
      if (empty !== 1'b1)     begin bad++; $display("FAIL mid_empty: got %b want 1", empty); end
      rst_n = 1; veh_req = 0; tick();
   endtask

   initial begin
      test_reset();
      test_entries();
      test_overflow();
      test_underflow();
      test_random();
      test_gate_handshake();
      test_gate_timeout();
      test_full_blocks();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
